// File: rtl/bp_be_fe_cmd_gen_if.sv
// Backend/front-end command bundle: resolved control flow in, redirect and attaboy commands out.
// master = command generator, slave = the surrounding backend/front-end.
interface bp_be_fe_cmd_gen_if #(
  parameter int vaddr_width_p               = 39,
  parameter int branch_metadata_fwd_width_p = 40
);
  logic                                   resolve_v_i;
  logic                                   resolve_ready_o;
  logic [vaddr_width_p-1:0]               resolve_pc_i;
  logic [vaddr_width_p-1:0]               resolve_npc_pred_i;
  logic [vaddr_width_p-1:0]               resolve_tgt_i;
  logic                                   resolve_br_i;
  logic                                   resolve_jmp_i;
  logic                                   resolve_taken_i;
  logic [branch_metadata_fwd_width_p-1:0] resolve_metadata_i;
  logic                                   flush_done_i;

  logic                                   redirect_v_o;
  logic [vaddr_width_p-1:0]               redirect_pc_o;
  logic                                   redirect_br_v_o;
  logic                                   redirect_br_taken_o;
  logic                                   redirect_br_ntaken_o;
  logic                                   redirect_br_nonbr_o;
  logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_fwd_o;

  logic                                   attaboy_v_o;
  logic                                   attaboy_yumi_i;
  logic [vaddr_width_p-1:0]               attaboy_pc_o;
  logic                                   attaboy_taken_o;
  logic                                   attaboy_ntaken_o;
  logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_fwd_o;

  logic [31:0]                            mispredict_cnt_o;

  modport master (
    input  resolve_v_i, resolve_pc_i, resolve_npc_pred_i, resolve_tgt_i,
           resolve_br_i, resolve_jmp_i, resolve_taken_i, resolve_metadata_i,
           flush_done_i, attaboy_yumi_i,
    output resolve_ready_o,
           redirect_v_o, redirect_pc_o, redirect_br_v_o, redirect_br_taken_o,
           redirect_br_ntaken_o, redirect_br_nonbr_o, redirect_br_metadata_fwd_o,
           attaboy_v_o, attaboy_pc_o, attaboy_taken_o, attaboy_ntaken_o,
           attaboy_br_metadata_fwd_o, mispredict_cnt_o
  );

  modport slave (
    output resolve_v_i, resolve_pc_i, resolve_npc_pred_i, resolve_tgt_i,
           resolve_br_i, resolve_jmp_i, resolve_taken_i, resolve_metadata_i,
           flush_done_i, attaboy_yumi_i,
    input  resolve_ready_o,
           redirect_v_o, redirect_pc_o, redirect_br_v_o, redirect_br_taken_o,
           redirect_br_ntaken_o, redirect_br_nonbr_o, redirect_br_metadata_fwd_o,
           attaboy_v_o, attaboy_pc_o, attaboy_taken_o, attaboy_ntaken_o,
           attaboy_br_metadata_fwd_o, mispredict_cnt_o
  );
endinterface

// File: rtl/bp_be_fe_cmd_gen.sv
// Turns resolved branches into FE redirects (1-cycle pulse) or queued attaboys (visible 1 cycle after accept).
// Backpressure: resolve_ready drops while the attaboy queue is full or a redirect/flush is in progress.

module bp_be_fe_cmd_gen_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clr_i,
  input  logic               enq_i,
  input  logic               deq_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o,
  output logic               empty_o,
  output logic               full_o
);
  localparam int ptr_w_lp = $clog2(els_p);

  logic [width_p-1:0] mem_q [els_p];
  logic [ptr_w_lp:0]  wr_ptr_q, rd_ptr_q;
  logic               wr_en, rd_en;

  assign wr_en   = enq_i & ~full_o;
  assign rd_en   = deq_i & ~empty_o;
  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[ptr_w_lp] != rd_ptr_q[ptr_w_lp])
                 & (wr_ptr_q[ptr_w_lp-1:0] == rd_ptr_q[ptr_w_lp-1:0]);
  assign data_o  = mem_q[rd_ptr_q[ptr_w_lp-1:0]];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[ptr_w_lp-1:0]] <= data_i;
  end
endmodule

module bp_be_fe_cmd_gen #(
  parameter int vaddr_width_p               = 39,
  parameter int branch_metadata_fwd_width_p = 40,
  parameter int attaboy_els_p               = 4
) (
  input logic                clk_i,
  input logic                reset_n_i,
  bp_be_fe_cmd_gen_if.master io
);
  typedef enum logic [1:0] {RUN, REDIR, FLUSH} state_e;

  typedef struct packed {
    logic [vaddr_width_p-1:0]               pc;
    logic                                   taken;
    logic                                   ntaken;
    logic [branch_metadata_fwd_width_p-1:0] metadata;
  } attaboy_t;

  typedef struct packed {
    logic [vaddr_width_p-1:0]               pc;
    logic                                   br_v;
    logic                                   taken;
    logic                                   ntaken;
    logic                                   nonbr;
    logic [branch_metadata_fwd_width_p-1:0] metadata;
  } redirect_t;

  state_e      state_q;
  redirect_t   redirect_q, redirect_n;
  logic        redirect_v_q;
  logic [31:0] mispredict_cnt_q;
  attaboy_t    atb_in, atb_out;
  logic        fifo_empty, fifo_full;
  logic        is_ctrl, accept, mispredict, redir_go, enq, deq;
  logic        unused_pc;

  // The resolved PC itself is not needed: commands carry the actual next PC.
  assign unused_pc = ^io.resolve_pc_i;

  assign is_ctrl    = io.resolve_br_i | io.resolve_jmp_i;
  assign io.resolve_ready_o = reset_n_i & (state_q == RUN) & ~fifo_full;
  assign accept     = io.resolve_v_i & io.resolve_ready_o;
  assign mispredict = (io.resolve_tgt_i != io.resolve_npc_pred_i);
  assign redir_go   = accept & mispredict;
  assign enq        = accept & ~mispredict & is_ctrl;
  assign io.attaboy_v_o = (state_q == RUN) & ~fifo_empty;
  assign deq        = io.attaboy_v_o & io.attaboy_yumi_i;

  always_comb begin
    redirect_n          = '0;
    redirect_n.pc       = io.resolve_tgt_i;
    redirect_n.br_v     = is_ctrl;
    redirect_n.taken    = is_ctrl & io.resolve_taken_i;
    redirect_n.ntaken   = io.resolve_br_i & ~io.resolve_taken_i;
    redirect_n.nonbr    = ~is_ctrl;
    redirect_n.metadata = io.resolve_metadata_i;

    atb_in          = '0;
    atb_in.pc       = io.resolve_tgt_i;
    atb_in.taken    = is_ctrl & io.resolve_taken_i;
    atb_in.ntaken   = io.resolve_br_i & ~io.resolve_taken_i;
    atb_in.metadata = io.resolve_metadata_i;
  end

  // A redirect squashes every queued attaboy, including one being consumed this cycle.
  bp_be_fe_cmd_gen_fifo #(
    .width_p ($bits(attaboy_t)),
    .els_p   (attaboy_els_p)
  ) attaboy_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (redir_go),
    .enq_i     (enq),
    .deq_i     (deq),
    .data_i    (atb_in),
    .data_o    (atb_out),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q          <= RUN;
      redirect_v_q     <= 1'b0;
      redirect_q       <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      redirect_v_q <= redir_go;
      redirect_q   <= redir_go ? redirect_n : '0;
      case (state_q)
        RUN: begin
          if (redir_go) begin
            state_q <= REDIR;
            if (mispredict_cnt_q != '1) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
          end
        end
        REDIR:   state_q <= FLUSH;
        FLUSH:   if (io.flush_done_i) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign io.redirect_v_o               = redirect_v_q;
  assign io.redirect_pc_o              = redirect_q.pc;
  assign io.redirect_br_v_o            = redirect_q.br_v;
  assign io.redirect_br_taken_o        = redirect_q.taken;
  assign io.redirect_br_ntaken_o       = redirect_q.ntaken;
  assign io.redirect_br_nonbr_o        = redirect_q.nonbr;
  assign io.redirect_br_metadata_fwd_o = redirect_q.metadata;

  assign io.attaboy_pc_o              = atb_out.pc;
  assign io.attaboy_taken_o           = atb_out.taken;
  assign io.attaboy_ntaken_o          = atb_out.ntaken;
  assign io.attaboy_br_metadata_fwd_o = atb_out.metadata;

  assign io.mispredict_cnt_o = mispredict_cnt_q;
endmodule

// File: tb/tb_bp_be_fe_cmd_gen.sv
// Scoreboard bench for bp_be_fe_cmd_gen: directed scenarios followed by randomized resolve traffic.
module tb_bp_be_fe_cmd_gen;
  localparam int VA  = 39;
  localparam int MW  = 40;
  localparam int ELS = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bp_be_fe_cmd_gen_if #(.vaddr_width_p(VA), .branch_metadata_fwd_width_p(MW)) io ();

  bp_be_fe_cmd_gen #(
    .vaddr_width_p               (VA),
    .branch_metadata_fwd_width_p (MW),
    .attaboy_els_p               (ELS)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .io        (io)
  );

  typedef struct {
    logic [VA-1:0] pc;
    logic          taken;
    logic          ntaken;
    logic [MW-1:0] md;
  } atb_t;

  typedef struct {
    logic [VA-1:0] pc;
    logic          br_v;
    logic          taken;
    logic          ntaken;
    logic          nonbr;
    logic [MW-1:0] md;
  } rdr_t;

  // Reference model: queued attaboys, pending redirects, and whether the backend is blocked.
  atb_t        exp_atb[$];
  rdr_t        exp_rdr[$];
  bit          redirect_due   = 1'b0;
  bit          awaiting_flush = 1'b0;
  int unsigned mcnt = 0;
  bit          m_ready = 1'b0;
  int          yumi_mode = 0;   // 0 never, 1 always, 2 random, 3 once
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [VA-1:0] rnd_va();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[VA-1:0];
  endfunction

  function automatic logic [MW-1:0] rnd_md();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[MW-1:0];
  endfunction

  // Monitor: compares every DUT output against the model at the negative edge and drives yumi.
  initial begin
    bit   exp_v, y;
    atb_t a;
    rdr_t r;
    io.attaboy_yumi_i = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      m_ready = reset_n && !redirect_due && !awaiting_flush && (exp_atb.size() < ELS);
      chk("resolve_ready", io.resolve_ready_o, m_ready);
      exp_v = !redirect_due && !awaiting_flush && (exp_atb.size() > 0);
      chk("attaboy_v", io.attaboy_v_o, exp_v);
      if (io.attaboy_v_o && exp_atb.size() > 0) begin
        a = exp_atb[0];
        chk("attaboy_cmd", {io.attaboy_pc_o, io.attaboy_taken_o, io.attaboy_ntaken_o,
                            io.attaboy_br_metadata_fwd_o}, {a.pc, a.taken, a.ntaken, a.md});
      end
      chk("redirect_v", io.redirect_v_o, redirect_due);
      if (io.redirect_v_o) begin
        if (exp_rdr.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL redirect_unexpected @%0t: got pc %0h expected none", $time, io.redirect_pc_o);
        end else begin
          r = exp_rdr.pop_front();
          chk("redirect_cmd", {io.redirect_pc_o, io.redirect_br_v_o, io.redirect_br_taken_o,
                               io.redirect_br_ntaken_o, io.redirect_br_nonbr_o,
                               io.redirect_br_metadata_fwd_o},
              {r.pc, r.br_v, r.taken, r.ntaken, r.nonbr, r.md});
        end
      end else begin
        chk("redirect_idle_zero", {io.redirect_pc_o, io.redirect_br_v_o, io.redirect_br_taken_o,
                                   io.redirect_br_ntaken_o, io.redirect_br_nonbr_o,
                                   io.redirect_br_metadata_fwd_o}, '0);
      end
      chk("mispredict_cnt", io.mispredict_cnt_o, mcnt);
      case (yumi_mode)
        1:       y = 1'b1;
        2:       y = ($urandom_range(0, 1) == 1);
        3: begin y = io.attaboy_v_o; if (y) yumi_mode = 0; end
        default: y = 1'b0;
      endcase
      io.attaboy_yumi_i = y;
      if (y && io.attaboy_v_o && exp_atb.size() > 0) void'(exp_atb.pop_front());
    end
  end

  // One stimulus cycle; acceptance is decided from the model's ready, not the DUT's.
  task automatic cyc(bit v, logic [VA-1:0] npc, logic [VA-1:0] tgt, bit br, bit jmp, bit tk,
                     logic [MW-1:0] md, bit fd, output bit acc);
    atb_t a;
    rdr_t r;
    @(negedge clk); #1;
    io.resolve_v_i        = v;
    io.resolve_pc_i       = rnd_va();
    io.resolve_npc_pred_i = npc;
    io.resolve_tgt_i      = tgt;
    io.resolve_br_i       = br;
    io.resolve_jmp_i      = jmp;
    io.resolve_taken_i    = tk;
    io.resolve_metadata_i = md;
    io.flush_done_i       = fd;
    acc = v && m_ready;
    if (redirect_due) begin
      redirect_due   = 1'b0;
      awaiting_flush = 1'b1;
    end else if (awaiting_flush && fd) begin
      awaiting_flush = 1'b0;
    end
    if (acc) begin
      if (tgt != npc) begin
        r.pc = tgt; r.br_v = br || jmp; r.taken = (br || jmp) && tk;
        r.ntaken = br && !tk; r.nonbr = !br && !jmp; r.md = md;
        exp_rdr.push_back(r);
        exp_atb.delete();
        redirect_due = 1'b1;
        if (mcnt != 32'hFFFF_FFFF) mcnt++;
      end else if (br || jmp) begin
        a.pc = tgt; a.taken = tk; a.ntaken = br && !tk; a.md = md;
        exp_atb.push_back(a);
      end
    end
  endtask

  task automatic send(logic [VA-1:0] npc, logic [VA-1:0] tgt, bit br, bit jmp, bit tk,
                      logic [MW-1:0] md);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 40) begin
      cyc(1'b1, npc, tgt, br, jmp, tk, md, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout @%0t: got no accept expected accept within 40 cycles", $time);
    end
  endtask

  task automatic idle(int n, bit fd);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, fd, acc);
  endtask

  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      reset_n = 1'b0;
      io.resolve_v_i = 1'b0;
      io.flush_done_i = 1'b0;
      exp_atb.delete();
      exp_rdr.delete();
      redirect_due = 1'b0;
      awaiting_flush = 1'b0;
      mcnt = 0;
    end
    @(negedge clk); #1;
    reset_n = 1'b1;
    io.resolve_v_i = 1'b0;
  endtask

  initial begin
    logic [VA-1:0] npc, tgt, msb;
    bit            acc, br, jmp;
    int            kind;
    io.resolve_v_i = 1'b0; io.resolve_pc_i = '0; io.resolve_npc_pred_i = '0;
    io.resolve_tgt_i = '0; io.resolve_br_i = 1'b0; io.resolve_jmp_i = 1'b0;
    io.resolve_taken_i = 1'b0; io.resolve_metadata_i = '0; io.flush_done_i = 1'b0;
    do_reset(3);
    idle(2, 1'b0);

    // Correct taken branch -> attaboy, consumed at once.
    yumi_mode = 1;
    send(39'h1000, 39'h1000, 1'b1, 1'b0, 1'b1, 40'hA1);
    idle(3, 1'b0);

    // Not-taken branch mispredicted -> redirect, blocked until the cycle after flush_done.
    send(39'h2000, 39'h2004, 1'b1, 1'b0, 1'b0, 40'hB2);
    idle(4, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Fill the queue with no consumer, then release exactly one entry, then drain in order.
    yumi_mode = 0;
    for (int i = 1; i <= 4; i++) send(39'h100 * i, 39'h100 * i, 1'b1, 1'b0, 1'b1, 40'(i));
    idle(3, 1'b0);
    yumi_mode = 3;
    idle(3, 1'b0);
    yumi_mode = 1;
    idle(5, 1'b0);

    // Two pending attaboys discarded by a non-branch mispredict.
    yumi_mode = 0;
    send(39'h500, 39'h500, 1'b0, 1'b1, 1'b1, 40'hC1);
    send(39'h600, 39'h600, 1'b1, 1'b0, 1'b0, 40'hC2);
    send(39'h3008, 39'h3004, 1'b0, 1'b0, 1'b0, 40'hC3);
    idle(3, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Reset while waiting for flush_done.
    send(39'h700, 39'h700, 1'b1, 1'b0, 1'b1, 40'hD1);
    send(39'h800, 39'h800, 1'b1, 1'b0, 1'b1, 40'hD2);
    send(39'h900, 39'h904, 1'b1, 1'b0, 1'b1, 40'hD3);
    idle(3, 1'b0);
    do_reset(2);
    idle(3, 1'b1);

    // Back-to-back enqueue with continuous consumption.
    yumi_mode = 1;
    for (int i = 0; i < 4; i++) send(39'hA00 + 39'(i), 39'hA00 + 39'(i), 1'b1, 1'b0, 1'b1, 40'(i + 16));
    idle(3, 1'b0);

    // Randomized traffic, including MSB-only mispredicts and stray flush_done.
    msb = '0;
    msb[VA-1] = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) yumi_mode = $urandom_range(0, 2);
      tgt = rnd_va();
      case ($urandom_range(0, 7))
        0:       npc = rnd_va();
        1:       npc = tgt ^ msb;
        default: npc = tgt;
      endcase
      kind = $urandom_range(0, 2);
      br   = (kind == 0);
      jmp  = (kind == 1);
      cyc($urandom_range(0, 3) != 0, npc, tgt, br, jmp, $urandom_range(0, 1) == 1, rnd_md(),
          $urandom_range(0, 3) == 0, acc);
    end
    yumi_mode = 1;
    idle(6, 1'b1);
    idle(4, 1'b0);

    if (exp_rdr.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL redirect_missing: got %0d outstanding expected 0", exp_rdr.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
